im_loader: RTL and testbench

Hardware program loader that fills the instruction memory from a byte stream, replacing the simulation-only hex-file preload. It sits between an external byte source (UART receiver or debug bridge) and the instruction memory write port inside sccomp. It holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.

---
 rtl/im_loader.sv | 91 +++++++++
 tb/tb_im_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: streams a checksummed program image into instruction memory and
// holds the CPU in reset until the whole image has been written and verified.
module im_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);
  localparam int MAX_WORDS = 2**ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [7:0] n_hi, acc;
  logic [15:0] n_hdr;
  logic [ADDR_WIDTH:0] n;
  logic [1:0] byte_idx;
  logic [23:0] shreg;
  logic fire, restart, hdr_bad, last_word;
  assign busy       = state inside {HDR_HI, HDR_LO, DATA, CHK};
  assign in_ready   = busy;
  assign done       = state == DONE;
  assign cpu_rstn   = done;
  assign err        = state == ERR;
  assign fire       = in_valid & in_ready;
  assign restart    = start & (state inside {IDLE, DONE, ERR});
  assign n_hdr      = {n_hi, in_data};
  assign hdr_bad    = n_hdr == 16'd0 || n_hdr > 16'(MAX_WORDS);
  assign last_word  = byte_idx == 2'd3 && word_count + (ADDR_WIDTH+1)'(1) == n;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // in_ready is high in every byte-accepting state, so in_valid alone marks a handshake there
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: state_nxt = start ? HDR_HI : state;
      HDR_HI:          state_nxt = in_valid ? HDR_LO : state;
      HDR_LO:          state_nxt = !in_valid ? state : hdr_bad ? ERR : DATA;
      DATA:            state_nxt = in_valid && last_word ? CHK : state;
      CHK:             state_nxt = !in_valid ? state : in_data == acc ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      n_hi       <= '0;
      n          <= '0;
      acc        <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      word_count <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
    end else begin
      im_we <= 1'b0;
      if (restart) begin
        word_count <= '0;
        byte_idx   <= '0;
        acc        <= '0;
      end
      if (fire)
        case (state)
          HDR_HI: n_hi <= in_data;
          HDR_LO: n <= n_hdr[ADDR_WIDTH:0];
          DATA: begin
            acc      <= acc ^ in_data;
            shreg    <= {shreg[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              im_we      <= 1'b1;
              im_addr    <= word_count[ADDR_WIDTH-1:0];
              im_wdata   <= {shreg, in_data};
              word_count <= word_count + (ADDR_WIDTH+1)'(1);
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed image loads; expected memory writes go through a
// scoreboard queue that a negedge monitor drains whenever im_we is seen.
module tb_im_loader;
  localparam int AW = 7;
  logic clk = 0, rstn = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, im_we, cpu_rstn, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [AW:0] word_count;
  int total = 0, bad = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0] img[$];
  always #5 clk = ~clk;
  im_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rstn && im_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h", im_addr, im_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("im_addr", 32'(im_addr), 32'(e[AW+31:32]));
        check("im_wdata", im_wdata, e[31:0]);
      end
    end
  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap, input bit st);
    int t = 0;
    if (gap) begin
      in_valid = 0;
      in_data = 8'hFF;
      @(posedge clk); #1;
    end
    in_valid = 1;
    in_data = b;
    start = st;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    start = 0;
  endtask
  task automatic load(input logic [15:0] n, input logic [7:0] chk, input bit gap, input int st_at);
    int p = 0;
    send(n[15:8], gap, 0);
    send(n[7:0], gap, 0);
    for (int i = 0; i < img.size(); i++)
      for (int k = 3; k >= 0; k--) begin
        logic [31:0] w;
        w = img[i];
        if (k == 0) exp_q.push_back({AW'(i), w});
        send(w[8*k +: 8], gap, p == st_at);
        p++;
      end
    send(chk, gap, 0);
  endtask
  task automatic check_end(input string tag, input logic d, input logic e, input int wc);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'(d));
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_word_count"}, 32'(word_count), wc);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_im_we"}, 32'(im_we), 0);
    check({tag, "_im_addr"}, 32'(im_addr), 0);
    check({tag, "_im_wdata"}, im_wdata, 0);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
  endtask
  initial begin
    #12;
    check_reset("rst");
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    do_start();
    check("start_in_ready", 32'(in_ready), 1);
    check("start_busy", 32'(busy), 1);
    img = '{32'h20080005, 32'h2009000A};
    load(16'd2, 8'h0E, 0, -1);
    check_end("two_words", 1, 0, 2);
    do_start();
    check("restart_cpu_rstn", 32'(cpu_rstn), 0);
    load(16'd2, 8'h0E, 1, -1);
    check_end("gapped", 1, 0, 2);
    do_start();
    img = '{32'h12345678};
    load(16'd1, 8'h00, 0, -1);
    check_end("bad_chk", 0, 1, 1);
    do_start();
    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    check_end("hdr_zero", 0, 1, 0);
    do_start();
    send(8'h00, 0, 0);
    send(8'h81, 0, 0);
    check_end("hdr_129", 0, 1, 0);
    do_start();
    send(8'h00, 0, 0);
    send(8'h04, 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    exp_q.push_back({AW'(0), 32'h11223344});
    send(8'h44, 0, 0);
    send(8'h55, 0, 0);
    send(8'h66, 0, 0);
    check("partial_word_count", 32'(word_count), 1);
    #2 rstn = 0;
    #1 check_reset("async_rst");
    @(posedge clk); #1;
    rstn = 1;
    do_start();
    img = '{32'hDEADBEEF};
    load(16'd1, 8'h22, 0, -1);
    check_end("after_rst", 1, 0, 1);
    do_start();
    check("b2b_cpu_rstn", 32'(cpu_rstn), 0);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_word_count", 32'(word_count), 0);
    img = '{32'h20080005, 32'h2009000A};
    load(16'd2, 8'h0E, 0, 2);
    check_end("b2b", 1, 0, 2);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
